// File: rtl/term_writer_if.sv
// Character-stream and BRAM-write bundle between the UART side, term_writer and
// the VGA text renderer.
//   slave  : term_writer side (consumes in_valid/in_data, drives everything else)
//   master : character source / observer side
// Parameters must match the term_writer instance: SAW = SCREEN_ADDRESS_WIDTH,
// CW = CHAR_WIDTH, COL_W = $clog2(H), ROW_W = $clog2(V).
interface term_writer_if #(
    parameter int unsigned SAW   = 13,
    parameter int unsigned CW    = 7,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 6
);
    logic             in_valid;
    logic [CW-1:0]    in_data;
    logic             in_ready;
    logic             bram_wen;
    logic [SAW-1:0]   bram_addr;
    logic [CW-1:0]    bram_data;
    logic [ROW_W-1:0] cursor_row;
    logic [COL_W-1:0] cursor_col;
    logic [ROW_W-1:0] top_row;

    modport master (
        output in_valid, in_data,
        input  in_ready, bram_wen, bram_addr, bram_data,
        input  cursor_row, cursor_col, top_row
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, bram_wen, bram_addr, bram_data,
        output cursor_row, cursor_col, top_row
    );
endinterface

// File: rtl/term_writer.sv
// term_writer: text-terminal writer. Accepts characters over a valid/ready
// handshake and writes them into the character BRAM read by the VGA renderer.
// Tracks a row/column cursor, handles CR, LF, BS and auto-wrap, scrolls by
// ring-buffering rows (top_row), and blanks new lines / the whole screen after
// reset with spaces.
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : term_writer_if.slave
//           in_valid/in_data/in_ready : character handshake
//           bram_wen/bram_addr/bram_data : one BRAM write per wen cycle
//           cursor_row/cursor_col : cursor (physical BRAM row)
//           top_row : physical row shown as screen line 0
// Optional feature: define TERM_WRITER_TAB_EN to enable HT (0x09) tab stops.
module term_writer #(
    parameter int unsigned SCREEN_ADDRESS_WIDTH  = 13,
    parameter int unsigned CHAR_WIDTH            = 7,
    parameter int unsigned HORIZONTAL_SLOT_COUNT = 80,
    parameter int unsigned VERTICAL_SLOT_COUNT   = 60,
    parameter int unsigned TAB_STOP              = 8
) (
    input  logic          clk,
    input  logic          rstn,
    term_writer_if.slave  bus
);
    localparam int unsigned SAW   = SCREEN_ADDRESS_WIDTH;
    localparam int unsigned H     = HORIZONTAL_SLOT_COUNT;
    localparam int unsigned V     = VERTICAL_SLOT_COUNT;
    localparam int unsigned COL_W = $clog2(H);
    localparam int unsigned ROW_W = $clog2(V);
    localparam int unsigned TOTAL = H * V;

    localparam logic [CHAR_WIDTH-1:0] CH_BS    = CHAR_WIDTH'(32'h08);
    localparam logic [CHAR_WIDTH-1:0] CH_HT    = CHAR_WIDTH'(32'h09);
    localparam logic [CHAR_WIDTH-1:0] CH_LF    = CHAR_WIDTH'(32'h0A);
    localparam logic [CHAR_WIDTH-1:0] CH_CR    = CHAR_WIDTH'(32'h0D);
    localparam logic [CHAR_WIDTH-1:0] CH_SPACE = CHAR_WIDTH'(32'h20);
    localparam logic [CHAR_WIDTH-1:0] CH_TILDE = CHAR_WIDTH'(32'h7E);

`ifdef TERM_WRITER_TAB_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        WRITE    = 2'd2,
        CLR_LINE = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        top_q, top_d;
    logic [SAW-1:0]          clr_idx_q, clr_idx_d;
    logic                    nl_pend_q, nl_pend_d;
    logic                    in_ready_q, in_ready_d;
    logic                    wen_q, wen_d;
    logic [SAW-1:0]          addr_q, addr_d;
    logic [CHAR_WIDTH-1:0]   data_q, data_d;

    logic                    do_nl_c;
    logic [ROW_W-1:0]        nl_row_c;
    logic [ROW_W-1:0]        nl_top_c;
    logic [31:0]             tab_tgt_c;
    logic                    printable_c;

    // Linear BRAM address of a cell; never exceeds TOTAL-1 for legal row/col.
    function automatic logic [SAW-1:0] addr_of(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
        return SAW'(r) * SAW'(H) + SAW'(c);
    endfunction

    // Row/top_row after a newline: wrap by compare, top follows when caught up.
    assign nl_row_c = (row_q == ROW_W'(V - 1)) ? '0 : row_q + ROW_W'(1);
    assign nl_top_c = (nl_row_c != top_q)        ? top_q :
                      (top_q == ROW_W'(V - 1))   ? '0    : top_q + ROW_W'(1);

    // Next tab stop strictly right of the cursor.
    assign tab_tgt_c = (32'(col_q) / TAB_STOP + 32'd1) * TAB_STOP;

    assign printable_c = (bus.in_data >= CH_SPACE) && (bus.in_data <= CH_TILDE);

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        top_d     = top_q;
        clr_idx_d = clr_idx_q;
        nl_pend_d = nl_pend_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        do_nl_c   = 1'b0;

        unique case (state_q)
            CLR_ALL: begin
                wen_d  = 1'b1;
                addr_d = clr_idx_q;
                data_d = CH_SPACE;
                if (clr_idx_q == SAW'(TOTAL - 1)) begin
                    clr_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + SAW'(1);
                end
            end

            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (printable_c) begin
                        wen_d   = 1'b1;
                        addr_d  = addr_of(row_q, col_q);
                        data_d  = bus.in_data;
                        state_d = WRITE;
                        // Last column: cursor stays until the write retires, then wraps.
                        if (col_q == COL_W'(H - 1)) begin
                            nl_pend_d = 1'b1;
                        end else begin
                            nl_pend_d = 1'b0;
                            col_d     = col_q + COL_W'(1);
                        end
                    end else if (bus.in_data == CH_LF) begin
                        do_nl_c = 1'b1;
                    end else if (bus.in_data == CH_CR) begin
                        col_d = '0;
                    end else if (bus.in_data == CH_BS) begin
                        if (col_q != '0) begin
                            col_d     = col_q - COL_W'(1);
                            wen_d     = 1'b1;
                            addr_d    = addr_of(row_q, col_q - COL_W'(1));
                            data_d    = CH_SPACE;
                            nl_pend_d = 1'b0;
                            state_d   = WRITE;
                        end
                    end else if (TAB_EN && (bus.in_data == CH_HT)) begin
                        if (tab_tgt_c >= H) begin
                            do_nl_c = 1'b1;
                        end else begin
                            col_d = COL_W'(tab_tgt_c);
                        end
                    end
                end
            end

            WRITE: begin
                if (nl_pend_q) begin
                    do_nl_c = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            CLR_LINE: begin
                wen_d  = 1'b1;
                addr_d = addr_of(row_q, COL_W'(clr_idx_q));
                data_d = CH_SPACE;
                if (clr_idx_q == SAW'(H - 1)) begin
                    clr_idx_d = '0;
                    state_d   = IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + SAW'(1);
                end
            end

            default: state_d = CLR_ALL;
        endcase

        if (do_nl_c) begin
            row_d     = nl_row_c;
            col_d     = '0;
            top_d     = nl_top_c;
            clr_idx_d = '0;
            nl_pend_d = 1'b0;
            state_d   = CLR_LINE;
        end

        // Ready only in a quiet IDLE cycle, so no write ever overlaps in_ready.
        in_ready_d = (state_d == IDLE) && !wen_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= CLR_ALL;
            row_q      <= '0;
            col_q      <= '0;
            top_q      <= '0;
            clr_idx_q  <= '0;
            nl_pend_q  <= 1'b0;
            in_ready_q <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            top_q      <= top_d;
            clr_idx_q  <= clr_idx_d;
            nl_pend_q  <= nl_pend_d;
            in_ready_q <= in_ready_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.bram_wen   = wen_q;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_data  = data_q;
    assign bus.cursor_row = row_q;
    assign bus.cursor_col = col_q;
    assign bus.top_row    = top_q;

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: directed scenarios plus random character traffic,
// checked against a cell-level model of the terminal (cursor, top row, and the
// ordered list of BRAM writes each character must cause).
module tb_term_writer;
    localparam int unsigned SAW   = 13;
    localparam int unsigned CW    = 7;
    localparam int unsigned H     = 80;
    localparam int unsigned V     = 60;
    localparam int unsigned TS    = 8;
    localparam int unsigned COL_W = $clog2(H);
    localparam int unsigned ROW_W = $clog2(V);
    localparam int unsigned TOTAL = H * V;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    term_writer_if #(.SAW(SAW), .CW(CW), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    term_writer #(
        .SCREEN_ADDRESS_WIDTH (SAW),
        .CHAR_WIDTH           (CW),
        .HORIZONTAL_SLOT_COUNT(H),
        .VERTICAL_SLOT_COUNT  (V),
        .TAB_STOP             (TS)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Terminal model state.
    int m_row, m_col, m_top;
    bit m_nl;
    int exp_w[$];
    int act_w[$];

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic void m_write(input int addr, input int data);
        exp_w.push_back(addr * 256 + data);
    endfunction

    function automatic void m_newline();
        m_row = (m_row == V - 1) ? 0 : m_row + 1;
        m_col = 0;
        if (m_row == m_top) m_top = (m_top + 1) % V;
        for (int j = 0; j < H; j++) m_write(m_row * H + j, 32'h20);
        m_nl = 1'b1;
    endfunction

    function automatic void m_char(input int c);
        int t;
        m_nl = 1'b0;
        t    = 0;
        if (c >= 32'h20 && c <= 32'h7E) begin
            m_write(m_row * H + m_col, c);
            if (m_col < H - 1) m_col++;
            else m_newline();
        end else if (c == 32'h0A) begin
            m_newline();
        end else if (c == 32'h0D) begin
            m_col = 0;
        end else if (c == 32'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_write(m_row * H + m_col, 32'h20);
            end
        end
`ifdef TERM_WRITER_TAB_EN
        else if (c == 32'h09) begin
            t = (m_col / TS + 1) * TS;
            if (t >= H) m_newline();
            else m_col = t;
        end
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, int'(bus.in_ready), 0);
        check({tag, "_wen"},   int'(bus.bram_wen), 0);
        check({tag, "_addr"},  int'(bus.bram_addr), 0);
        check({tag, "_data"},  int'(bus.bram_data), 0);
        check({tag, "_row"},   int'(bus.cursor_row), 0);
        check({tag, "_col"},   int'(bus.cursor_col), 0);
        check({tag, "_top"},   int'(bus.top_row), 0);
    endtask

    // Called at the negedge where rstn has just been released.
    task automatic run_clear();
        int bad;
        int k;
        k = 0;
        while (!bus.bram_wen && k < 8) begin
            @(negedge clk);
            k++;
        end
        bad = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (!(bus.bram_wen == 1'b1 && int'(bus.bram_addr) == i &&
                  int'(bus.bram_data) == 32'h20 && bus.in_ready == 1'b0)) bad++;
            @(negedge clk);
        end
        check("clr_all_bad_cycles", bad, 0);
        check("clr_all_end_wen", int'(bus.bram_wen), 0);
        check("clr_all_ready", int'(bus.in_ready), 1);
        m_row = 0;
        m_col = 0;
        m_top = 0;
    endtask

    // Entered at a negedge with in_ready=1; returns at a negedge with in_ready=1.
    task automatic send_char(input int c, input string tag);
        int  busy;
        int  first_k;
        bit  done;
        int  n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_w.delete();
        act_w.delete();
        m_char(c);
        bus.in_valid = 1'b1;
        bus.in_data  = CW'(c);
        @(posedge clk);
        busy    = 0;
        first_k = -1;
        done    = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.bram_wen) begin
                if (first_k < 0) first_k = k;
                act_w.push_back(int'(bus.bram_addr) * 256 + int'(bus.bram_data));
            end
            if (bus.in_ready) begin
                bus.in_valid = 1'b0;
                done = 1'b1;
                break;
            end
            busy++;
            // Noise while not ready must be ignored by the writer.
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = CW'($urandom);
        end
        bus.in_valid = 1'b0;
        check({tag, "_ready_timeout"}, int'(done), 1);
        check({tag, "_nwrites"}, act_w.size(), exp_w.size());
        n = (act_w.size() < exp_w.size()) ? act_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, act_w[i], exp_w[i]);
        check({tag, "_row"}, int'(bus.cursor_row), m_row);
        check({tag, "_col"}, int'(bus.cursor_col), m_col);
        check({tag, "_top"}, int'(bus.top_row), m_top);
        if (!m_nl) begin
            check({tag, "_busy"}, busy, exp_w.size());
            if (exp_w.size() > 0) check({tag, "_wr_latency"}, first_k, 0);
        end
    endtask

    function automatic int rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70)      return $urandom_range(32'h20, 32'h7E);
        else if (r < 76) return 32'h0A;
        else if (r < 82) return 32'h0D;
        else if (r < 90) return 32'h08;
        else if (r < 94) return 32'h09;
        else if (r < 97) return 32'h7F;
        else             return $urandom_range(0, 32'h1F);
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rstn         = 1'b0;
        m_row = 0;
        m_col = 0;
        m_top = 0;
        m_nl  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;
        run_clear();

        // Single printable at (0,0).
        send_char(32'h41, "char_A");
        send_char(32'h0D, "cr");

        // Full line from column 0 wraps and blanks row 1.
        for (int i = 0; i < H; i++) send_char(32'h42, "line_B");

        // Reset in the middle of a line clear.
        bus.in_valid = 1'b1;
        bus.in_data  = CW'(32'h0A);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_clr_wen", int'(bus.bram_wen), 1);
        #2 rstn = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        run_clear();

        // 60 LFs: row wraps to 0 and top_row moves on the last one.
        for (int i = 0; i < V; i++) send_char(32'h0A, "lf_scroll");
        check("scroll_top", int'(bus.top_row), 1);

        // "AB", BS, CR, BS.
        send_char(32'h41, "bs_A");
        send_char(32'h42, "bs_B");
        send_char(32'h08, "bs_1");
        send_char(32'h0D, "bs_cr");
        send_char(32'h08, "bs_col0");

        // HT at column 77.
        send_char(32'h0D, "tab_cr");
        for (int i = 0; i < 77; i++) send_char($urandom_range(32'h20, 32'h7E), "tab_fill");
        send_char(32'h09, "tab_77");

        // Random traffic.
        for (int i = 0; i < 400; i++) send_char(rand_char(), "rand");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
